matvec_row_scheduler: RTL
=========================

# matvec_row_scheduler

Sequences the shared 4-multiplier row-by-column dot-product engine over all rows of a matrix to form a matrix-vector product for the RLS gain/update path. Per row it selects the row and pulses the engine's restart. It then waits the engine's fixed accumulate latency, captures the scalar result and hands it downstream on a valid/ready stream. A start/done handshake frames each full product; an abort input cancels a product in flight.

## Interface
- WIDTH, 32, data width of engine result and output stream
- ROWS, 16, rows per matrix-vector product (>=1)
- DP_LAT, 6, cycles from engine restart pulse to stable engine result (SIZE/COMBSIZE+2 for SIZE=16, COMBSIZE=4); must be >=1
- RW, $clog2(ROWS) (min 1), row index width (derived localparam)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request one full product; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE from any state next cycle
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after last row accepted downstream
- dp_restart  output  1  restart pulse to dot-product engine
- dp_row_sel  output  RW  row currently fed to engine (drives matrix row mux)
- dp_y  input  WIDTH  engine result
- res_valid  output  1  result beat valid
- res_ready  input  1  downstream accepts beat
- res_data  output  WIDTH  captured engine result for row res_idx
- res_idx  output  RW  row index of res_data
- res_last  output  1  high with res_valid on row ROWS-1

## Operation
- States: IDLE, RESTART, WAIT, EMIT, DONE.
- IDLE: busy=0. When start=1, clear row counter r=0 and go to RESTART.
- RESTART: one cycle with dp_restart=1 and dp_row_sel=r. Clear the wait counter and go to WAIT.
- WAIT: counter counts 0..DP_LAT-1. On the cycle it equals DP_LAT-1, register res_data<=dp_y and res_idx<=r, then go to EMIT.
- EMIT: res_valid=1, res_last=(r==ROWS-1).
  - If res_ready=1 and r==ROWS-1, go to DONE.
  - If res_ready=1 and r<ROWS-1, set r<=r+1 and go to RESTART.
  - If res_ready=0, hold. res_data, res_idx and res_last stay stable, and the engine is not restarted.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- dp_row_sel=r and is stable from RESTART through EMIT of that row. In IDLE it holds its last value.
- abort=1 in any state: next state is IDLE, res_valid drops, done is not asserted. abort has priority over start and res_ready.
- start while busy is ignored (not queued). start and abort both high in IDLE gives IDLE.
- res_data is a plain register copy of dp_y; no arithmetic or width change.
- Reset mid-product: immediate IDLE. All outputs, r and the wait counter clear. No done is produced.

## Timing
- Reset values: busy=0, done=0, dp_restart=0, dp_row_sel=0, res_valid=0, res_data=0, res_idx=0, res_last=0.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.
- start sampled at edge 0 gives dp_restart high in cycle 1 and WAIT in cycles 2..DP_LAT+1. dp_y is sampled at the end of cycle DP_LAT+1, and res_valid is high from cycle DP_LAT+2.
- With res_ready held high, each row takes DP_LAT+2 cycles. done is high in cycle 1+ROWS*(DP_LAT+2); for the defaults that is cycle 129.
- Each cycle of res_ready=0 in EMIT adds exactly one cycle.
- Back-to-back products: start in the cycle after done is accepted. IDLE lasts at least one cycle.

## Test plan
- ROWS=4, DP_LAT=6, res_ready=1, dp_y=0x100+row_sel, start at cycle 0.
  - dp_restart pulses at cycles 1, 9, 17, 25.
  - Beats (idx,data) = (0,0x100), (1,0x101), (2,0x102), (3,0x103) at cycles 8, 16, 24, 32.
  - res_last only on idx 3; done at cycle 33.
- Backpressure: res_ready=0 for 5 cycles on the row-1 beat -> res_data=0x101 stable throughout, next dp_restart delayed 5 cycles, done at cycle 38.
- Abort: assert abort during WAIT of row 2 -> IDLE next cycle, busy=0, no done. A new start then restarts from row 0.
- start pulsed while busy at row 1 -> ignored, exactly 4 beats and one done.
- Async reset asserted mid-EMIT, between clock edges -> all outputs read 0 immediately. After release, start gives a normal 4-row sequence.
- ROWS=1, DP_LAT=1 -> dp_restart at cycle 1, beat at cycle 3 with res_last=1, done at cycle 4.

Source files
------------

// File: rtl/matvec_row_scheduler_if.sv
// Handshake/bus bundle between the row scheduler, the dot-product engine and the result sink.
// master: scheduler side (start/abort/dp_y/res_ready in; status, engine control, result beat out).
interface matvec_row_scheduler_if #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 16
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             dp_restart;
  logic [RW-1:0]    dp_row_sel;
  logic [WIDTH-1:0] dp_y;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [RW-1:0]    res_idx;
  logic             res_last;

  modport master (
    input  start, abort, dp_y, res_ready,
    output busy, done, dp_restart, dp_row_sel,
    output res_valid, res_data, res_idx, res_last
  );

  modport slave (
    output start, abort, dp_y, res_ready,
    input  busy, done, dp_restart, dp_row_sel,
    input  res_valid, res_data, res_idx, res_last
  );
endinterface

// File: rtl/matvec_row_scheduler.sv
// Row sequencer for the shared dot-product engine: restart, wait DP_LAT, emit one beat per row.
// Ports: clk, reset (async, active-high), bus (master modport of matvec_row_scheduler_if).
module matvec_row_scheduler #(
  parameter int WIDTH  = 32,
  parameter int ROWS   = 16,
  parameter int DP_LAT = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  matvec_row_scheduler_if.master bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DP_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESTART,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [RW-1:0]    idx_q, idx_d;
  logic             last_q, last_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    // abort wins over everything and leaves the row select untouched
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            r_d     = '0;
            state_d = S_RESTART;
          end
        end
        S_RESTART: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == C_LAST) begin
            data_d  = bus.dp_y;
            idx_d   = r_q;
            last_d  = (r_q == R_LAST);
            state_d = S_EMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_EMIT: begin
          if (bus.res_ready) begin
            if (r_q == R_LAST) begin
              state_d = S_DONE;
            end else begin
              r_d     = r_q + 1'b1;
              state_d = S_RESTART;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.dp_restart = (state_q == S_RESTART);
  assign bus.dp_row_sel = r_q;
  assign bus.res_valid  = (state_q == S_EMIT);
  assign bus.res_data   = data_q;
  assign bus.res_idx    = idx_q;
  assign bus.res_last   = last_q;
endmodule
